// File: rtl/bip2_pkg.sv
// Shared encodings for the BIP2 control path: opcodes, sequencer states and
// the datapath mux/ALU select values driven by the sequencer.
package bip2_pkg;

   typedef enum logic [4:0] {
      OpHlt  = 5'd0,
      OpSto  = 5'd1,
      OpLd   = 5'd2,
      OpLdi  = 5'd3,
      OpAdd  = 5'd4,
      OpAddi = 5'd5,
      OpSub  = 5'd6,
      OpSubi = 5'd7,
      OpBeq  = 5'd8,
      OpBne  = 5'd9,
      OpBgt  = 5'd10,
      OpBge  = 5'd11,
      OpBlt  = 5'd12,
      OpBle  = 5'd13,
      OpJmp  = 5'd14
   } opcode_e;

   // StResume is the single PC-advance cycle between HALT and FETCH.
   typedef enum logic [2:0] {
      StReset,
      StFetch,
      StDecode,
      StExecute,
      StDmem,
      StHalt,
      StResume
   } state_e;

   localparam logic [1:0] SelAAlu     = 2'd0;
   localparam logic [1:0] SelAOperand = 2'd1;
   localparam logic [1:0] SelAMem     = 2'd2;

   localparam logic SelBMem     = 1'b0;
   localparam logic SelBOperand = 1'b1;

   localparam logic AluAdd = 1'b0;
   localparam logic AluSub = 1'b1;

   function automatic logic is_mem_op(input logic [4:0] op);
      logic mem;
      case (op)
         OpLd, OpSto, OpAdd, OpSub: mem = 1'b1;
         default:                   mem = 1'b0;
      endcase
      return mem;
   endfunction

endpackage

// File: rtl/branch_condition.sv
// Combinational branch resolution: decides whether the PC loads the operand
// for the given opcode and the registered Z/N flags.
module branch_condition
   import bip2_pkg::*;
(
   input  logic [4:0] opcode_i,
   input  logic       z_i,
   input  logic       n_i,
   output logic       take_o
);

   always_comb begin
      take_o = 1'b0;
      case (opcode_i)
         OpBeq:   take_o = z_i;
         OpBne:   take_o = ~z_i;
         OpBgt:   take_o = ~z_i & ~n_i;
         OpBge:   take_o = ~n_i;
         OpBlt:   take_o = n_i;
         OpBle:   take_o = n_i | z_i;
         OpJmp:   take_o = 1'b1;
         default: take_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute controller for BIP2 with memory wait-state
// handshakes, halt/resume and a retired-instruction counter.
module instruction_sequencer
   import bip2_pkg::*;
#(
   parameter int unsigned OPCODE_WIDTH = 5,
   parameter int unsigned COUNT_WIDTH  = 16
) (
   input  logic                    clock_in,
   input  logic                    reset_in,
   input  logic [OPCODE_WIDTH-1:0] opcode_in,
   input  logic                    status_Z_in,
   input  logic                    status_N_in,
   input  logic                    imem_ready_in,
   input  logic                    dmem_ready_in,
   input  logic                    run_in,
   output logic                    imem_req_out,
   output logic                    dmem_req_out,
   output logic                    ir_wr_out,
   output logic                    pc_wr_out,
   output logic                    acc_wr_out,
   output logic                    status_wr_out,
   output logic                    data_memory_wr_out,
   output logic                    ir_reset_out,
   output logic                    pc_reset_out,
   output logic                    acc_reset_out,
   output logic                    status_reset_out,
   output logic                    branch_out,
   output logic [1:0]              sel_A_out,
   output logic                    sel_B_out,
   output logic                    alu_op_out,
   output logic                    halted_out,
   output logic [COUNT_WIDTH-1:0]  retired_count_out
);

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [4:0]             op;
   logic                   take;
   logic                   retire;

   // The IR only changes in FETCH, so the opcode is stable from DECODE onward.
   assign op = 5'(opcode_in);

   branch_condition u_branch_condition (
      .opcode_i (op),
      .z_i      (status_Z_in),
      .n_i      (status_N_in),
      .take_o   (take)
   );

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StReset:   state_d = StFetch;
         StFetch:   if (imem_ready_in) state_d = StDecode;
         StDecode: begin
            if (op == OpHlt) begin
               state_d = StHalt;
            end else if (is_mem_op(op)) begin
               state_d = StDmem;
            end else begin
               state_d = StExecute;
            end
         end
         StExecute: state_d = StFetch;
         StDmem:    if (dmem_ready_in) state_d = StFetch;
         StHalt:    if (run_in) state_d = StResume;
         StResume:  state_d = StFetch;
         default:   state_d = StReset;
      endcase
   end

   always_comb begin
      imem_req_out       = 1'b0;
      dmem_req_out       = 1'b0;
      ir_wr_out          = 1'b0;
      pc_wr_out          = 1'b0;
      acc_wr_out         = 1'b0;
      status_wr_out      = 1'b0;
      data_memory_wr_out = 1'b0;
      ir_reset_out       = 1'b0;
      pc_reset_out       = 1'b0;
      acc_reset_out      = 1'b0;
      status_reset_out   = 1'b0;
      branch_out         = 1'b0;
      sel_A_out          = SelAAlu;
      sel_B_out          = SelBMem;
      alu_op_out         = AluAdd;
      halted_out         = 1'b0;
      case (state_q)
         StReset: begin
            ir_reset_out     = 1'b1;
            pc_reset_out     = 1'b1;
            acc_reset_out    = 1'b1;
            status_reset_out = 1'b1;
         end
         StFetch: begin
            imem_req_out = 1'b1;
            ir_wr_out    = imem_ready_in;
         end
         StDmem: begin
            dmem_req_out       = 1'b1;
            data_memory_wr_out = (op == OpSto);
            if (dmem_ready_in) begin
               pc_wr_out = 1'b1;
               case (op)
                  OpLd: begin
                     acc_wr_out = 1'b1;
                     sel_A_out  = SelAMem;
                  end
                  OpAdd, OpSub: begin
                     acc_wr_out    = 1'b1;
                     status_wr_out = 1'b1;
                     sel_A_out     = SelAAlu;
                     sel_B_out     = SelBMem;
                     alu_op_out    = (op == OpSub) ? AluSub : AluAdd;
                  end
                  default: ;
               endcase
            end
         end
         StExecute: begin
            pc_wr_out  = 1'b1;
            branch_out = take;
            case (op)
               OpLdi: begin
                  acc_wr_out = 1'b1;
                  sel_A_out  = SelAOperand;
               end
               OpAddi, OpSubi: begin
                  acc_wr_out    = 1'b1;
                  status_wr_out = 1'b1;
                  sel_A_out     = SelAAlu;
                  sel_B_out     = SelBOperand;
                  alu_op_out    = (op == OpSubi) ? AluSub : AluAdd;
               end
               default: ;
            endcase
         end
         StHalt:   halted_out = 1'b1;
         StResume: pc_wr_out  = 1'b1;
         default: ;
      endcase
   end

   // An instruction retires on its last cycle; HLT retires as HALT is entered.
   assign retire = (state_q == StExecute)
                 | ((state_q == StDmem) & dmem_ready_in)
                 | ((state_q == StDecode) & (op == OpHlt));

   assign count_d = retire ? count_q + 1'b1 : count_q;

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign retired_count_out = count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: per-cycle strobe vectors compared
// against hand-computed expectations, plus retired-counter tracking.
module tb_instruction_sequencer;

   // Narrow counter so the wrap scenario fits in a short run.
   localparam int unsigned CW = 12;

   localparam logic [16:0] O_IMEM     = 17'h10000;
   localparam logic [16:0] O_DREQ     = 17'h08000;
   localparam logic [16:0] O_IRW      = 17'h04000;
   localparam logic [16:0] O_PCW      = 17'h02000;
   localparam logic [16:0] O_ACCW     = 17'h01000;
   localparam logic [16:0] O_STW      = 17'h00800;
   localparam logic [16:0] O_DMW      = 17'h00400;
   localparam logic [16:0] O_RST      = 17'h003C0;
   localparam logic [16:0] O_BR       = 17'h00020;
   localparam logic [16:0] O_SELA_MEM = 17'h00010;
   localparam logic [16:0] O_SELA_OP  = 17'h00008;
   localparam logic [16:0] O_SELB_OP  = 17'h00004;
   localparam logic [16:0] O_SUB      = 17'h00002;
   localparam logic [16:0] O_HALT     = 17'h00001;

   localparam int NEX = 18;
   localparam logic [4:0] EX_OP [0:NEX-1] = '{
      5'd3, 5'd5, 5'd7, 5'd8, 5'd13, 5'd8, 5'd9, 5'd9, 5'd10,
      5'd10, 5'd11, 5'd11, 5'd12, 5'd13, 5'd14, 5'd20, 5'd15, 5'd31};
   localparam logic EX_Z [0:NEX-1] = '{
      0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1};
   localparam logic EX_N [0:NEX-1] = '{
      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1};
   localparam logic [16:0] EX_EXP [0:NEX-1] = '{
      O_PCW | O_ACCW | O_SELA_OP,
      O_PCW | O_ACCW | O_STW | O_SELB_OP,
      O_PCW | O_ACCW | O_STW | O_SELB_OP | O_SUB,
      O_PCW | O_BR,
      O_PCW,
      O_PCW,
      O_PCW | O_BR,
      O_PCW,
      O_PCW | O_BR,
      O_PCW,
      O_PCW | O_BR,
      O_PCW,
      O_PCW | O_BR,
      O_PCW | O_BR,
      O_PCW | O_BR,
      O_PCW,
      O_PCW,
      O_PCW};

   localparam logic [4:0] MEM_OP [0:2] = '{5'd1, 5'd4, 5'd6};
   localparam logic [16:0] MEM_EXP [0:2] = '{
      O_DREQ | O_DMW | O_PCW,
      O_DREQ | O_PCW | O_ACCW | O_STW,
      O_DREQ | O_PCW | O_ACCW | O_STW | O_SUB};

   logic          clk = 1'b0;
   logic          reset_in = 1'b1;
   logic [4:0]    opcode_in = 5'd0;
   logic          z_in = 1'b0;
   logic          n_in = 1'b0;
   logic          imem_ready = 1'b0;
   logic          dmem_ready = 1'b0;
   logic          run_in = 1'b0;
   logic          imem_req, dmem_req, ir_wr, pc_wr, acc_wr, status_wr, dmem_wr;
   logic          ir_rst, pc_rst, acc_rst, st_rst, branch, sel_b, alu_op, halted;
   logic [1:0]    sel_a;
   logic [CW-1:0] count;
   logic [16:0]   outs;
   logic [CW-1:0] exp_count = '0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   instruction_sequencer #(
      .OPCODE_WIDTH (5),
      .COUNT_WIDTH  (CW)
   ) dut (
      .clock_in           (clk),
      .reset_in           (reset_in),
      .opcode_in          (opcode_in),
      .status_Z_in        (z_in),
      .status_N_in        (n_in),
      .imem_ready_in      (imem_ready),
      .dmem_ready_in      (dmem_ready),
      .run_in             (run_in),
      .imem_req_out       (imem_req),
      .dmem_req_out       (dmem_req),
      .ir_wr_out          (ir_wr),
      .pc_wr_out          (pc_wr),
      .acc_wr_out         (acc_wr),
      .status_wr_out      (status_wr),
      .data_memory_wr_out (dmem_wr),
      .ir_reset_out       (ir_rst),
      .pc_reset_out       (pc_rst),
      .acc_reset_out      (acc_rst),
      .status_reset_out   (st_rst),
      .branch_out         (branch),
      .sel_A_out          (sel_a),
      .sel_B_out          (sel_b),
      .alu_op_out         (alu_op),
      .halted_out         (halted),
      .retired_count_out  (count)
   );

   assign outs = {imem_req, dmem_req, ir_wr, pc_wr, acc_wr, status_wr, dmem_wr,
                  ir_rst, pc_rst, acc_rst, st_rst, branch, sel_a, sel_b, alu_op, halted};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_in = 1'b1;
      run_in   = 1'b1;
      tick();
      tick();
      tick();
      if (outs !== O_RST) begin
         errors++;
         $display("FAIL reset_held: outs=%h expected=%h", outs, O_RST);
      end
      checks++;
      if (count !== '0) begin
         errors++;
         $display("FAIL reset_count: got=%0d expected=0", count);
      end
      checks++;
      reset_in = 1'b0;
      run_in   = 1'b0;
      #1;
      if (outs !== O_RST) begin
         errors++;
         $display("FAIL reset_first_cycle: outs=%h expected=%h", outs, O_RST);
      end
      checks++;
      tick();
   endtask

   task automatic test_ldi();
      opcode_in  = 5'd3;
      imem_ready = 1'b1;
      #1;
      if (outs !== (O_IMEM | O_IRW)) begin
         errors++;
         $display("FAIL ldi_fetch: outs=%h expected=%h", outs, O_IMEM | O_IRW);
      end
      checks++;
      tick();
      if (outs !== 17'h0) begin
         errors++;
         $display("FAIL ldi_decode: outs=%h expected=0", outs);
      end
      checks++;
      tick();
      if (outs !== (O_PCW | O_ACCW | O_SELA_OP)) begin
         errors++;
         $display("FAIL ldi_execute: outs=%h expected=%h", outs, O_PCW | O_ACCW | O_SELA_OP);
      end
      checks++;
      tick();
      exp_count++;
      if (count !== exp_count) begin
         errors++;
         $display("FAIL ldi_retired: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
   endtask

   task automatic test_ld_wait();
      opcode_in  = 5'd2;
      imem_ready = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         if (outs !== O_IMEM) begin
            errors++;
            $display("FAIL fetch_wait%0d: outs=%h expected=%h", i, outs, O_IMEM);
         end
         checks++;
         tick();
      end
      imem_ready = 1'b1;
      #1;
      if (outs !== (O_IMEM | O_IRW)) begin
         errors++;
         $display("FAIL ld_fetch_ready: outs=%h expected=%h", outs, O_IMEM | O_IRW);
      end
      checks++;
      tick();
      imem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (outs !== O_DREQ) begin
            errors++;
            $display("FAIL ld_dmem_wait%0d: outs=%h expected=%h", i, outs, O_DREQ);
         end
         checks++;
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      if (outs !== (O_DREQ | O_PCW | O_ACCW | O_SELA_MEM)) begin
         errors++;
         $display("FAIL ld_dmem_ready: outs=%h expected=%h", outs,
                  O_DREQ | O_PCW | O_ACCW | O_SELA_MEM);
      end
      checks++;
      tick();
      dmem_ready = 1'b0;
      exp_count++;
      #1;
      if (count !== exp_count) begin
         errors++;
         $display("FAIL ld_retired: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
      if (outs !== O_IMEM) begin
         errors++;
         $display("FAIL ld_back_to_fetch: outs=%h expected=%h", outs, O_IMEM);
      end
      checks++;
   endtask

   task automatic test_mem_ops();
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         opcode_in = MEM_OP[i];
         #1;
         tick();
         if (outs !== 17'h0) begin
            errors++;
            $display("FAIL mem_decode op=%0d: outs=%h expected=0", MEM_OP[i], outs);
         end
         checks++;
         tick();
         if (outs !== MEM_EXP[i]) begin
            errors++;
            $display("FAIL mem_dmem op=%0d: outs=%h expected=%h", MEM_OP[i], outs, MEM_EXP[i]);
         end
         checks++;
         tick();
         exp_count++;
      end
      dmem_ready = 1'b0;
      if (count !== exp_count) begin
         errors++;
         $display("FAIL mem_retired: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
   endtask

   task automatic test_exec();
      imem_ready = 1'b1;
      for (int i = 0; i < NEX; i++) begin
         opcode_in = EX_OP[i];
         z_in      = EX_Z[i];
         n_in      = EX_N[i];
         tick();
         tick();
         if (outs !== EX_EXP[i]) begin
            errors++;
            $display("FAIL exec op=%0d z=%0b n=%0b: outs=%h expected=%h",
                     EX_OP[i], EX_Z[i], EX_N[i], outs, EX_EXP[i]);
         end
         checks++;
         tick();
         exp_count++;
      end
      z_in = 1'b0;
      n_in = 1'b0;
      if (count !== exp_count) begin
         errors++;
         $display("FAIL exec_retired: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
   endtask

   task automatic test_halt();
      opcode_in  = 5'd0;
      imem_ready = 1'b1;
      tick();
      tick();
      exp_count++;
      if (count !== exp_count) begin
         errors++;
         $display("FAIL halt_retired: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
      dmem_ready = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         if (outs !== O_HALT) begin
            errors++;
            $display("FAIL halt_hold%0d: outs=%h expected=%h", i, outs, O_HALT);
         end
         checks++;
         tick();
      end
      dmem_ready = 1'b0;
      run_in     = 1'b1;
      #1;
      if (outs !== O_HALT) begin
         errors++;
         $display("FAIL halt_run_sample: outs=%h expected=%h", outs, O_HALT);
      end
      checks++;
      tick();
      run_in = 1'b0;
      #1;
      if (outs !== O_PCW) begin
         errors++;
         $display("FAIL halt_resume: outs=%h expected=%h", outs, O_PCW);
      end
      checks++;
      tick();
      if (outs !== (O_IMEM | O_IRW)) begin
         errors++;
         $display("FAIL halt_refetch: outs=%h expected=%h", outs, O_IMEM | O_IRW);
      end
      checks++;
      if (count !== exp_count) begin
         errors++;
         $display("FAIL halt_count_stable: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
   endtask

   task automatic test_reset_mid_sto();
      opcode_in  = 5'd1;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         if (outs !== (O_DREQ | O_DMW)) begin
            errors++;
            $display("FAIL sto_wait%0d: outs=%h expected=%h", i, outs, O_DREQ | O_DMW);
         end
         checks++;
         tick();
      end
      reset_in = 1'b1;
      run_in   = 1'b1;
      tick();
      exp_count = '0;
      if (outs !== O_RST) begin
         errors++;
         $display("FAIL sto_reset: outs=%h expected=%h", outs, O_RST);
      end
      checks++;
      if (count !== exp_count) begin
         errors++;
         $display("FAIL sto_reset_count: got=%0d expected=0", count);
      end
      checks++;
      dmem_ready = 1'b1;
      tick();
      if (outs !== O_RST) begin
         errors++;
         $display("FAIL reset_over_ready: outs=%h expected=%h", outs, O_RST);
      end
      checks++;
      reset_in   = 1'b0;
      run_in     = 1'b0;
      dmem_ready = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      opcode_in  = 5'd20;
      imem_ready = 1'b1;
      for (int i = 0; i < (1 << CW) - 1; i++) begin
         tick();
         tick();
         tick();
         exp_count++;
      end
      if (count !== exp_count || count !== {CW{1'b1}}) begin
         errors++;
         $display("FAIL wrap_full: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
      tick();
      tick();
      if (outs !== O_PCW) begin
         errors++;
         $display("FAIL wrap_illegal_exec: outs=%h expected=%h", outs, O_PCW);
      end
      checks++;
      tick();
      exp_count++;
      if (count !== exp_count || count !== '0) begin
         errors++;
         $display("FAIL wrap_zero: got=%0d expected=%0d", count, exp_count);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_ld_wait();
      test_mem_ops();
      test_exec();
      test_halt();
      test_reset_mid_sto();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
